// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: one operand pair per valid/ready
// transaction, DIGIT bits per clock, result held with carry/overflow flags until taken.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready_o high
// CALC  | processing one DIGIT-wide slice per clock, busy_o high
// DONE  | result presented on s_o/cout_o/ovf_o, out_valid_o high

module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("addsub_serial: WIDTH must be >= 2 and divisible by DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] dig_ext;
    logic             cmsb;
    logic             last;

    // Carry into the top bit of the current slice, recovered from its sum bit.
    always_comb begin
        dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        dig_ext = WIDTH'(dsum[DIGIT-1:0]);
        cmsb    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
        last    = (cnt_q == CW'(NDIG - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i ^ {WIDTH{sub_i}};
                    carry_d = cin_i ^ sub_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    s_d     = acc_d;
                    cout_d  = dsum[DIGIT];
                    ovf_d   = cmsb ^ dsum[DIGIT];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_CALC);
    assign s_o         = s_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: directed cases on a DIGIT=2 build, then random
// traffic with backpressure on DIGIT=2, 8 and 1 builds against an arithmetic model.

module tb_addsub_serial;

    localparam int W = 8;
    localparam int N = 3;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid [N];
    logic         in_ready [N];
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic         cin [N];
    logic         sub [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic [W-1:0] s [N];
    logic         cout [N];
    logic         ovf [N];
    logic         busy [N];

    exp_t sb [N][$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rand_mode = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic exp_t mk(input logic [W-1:0] sv, input logic c, input logic o);
        exp_t e;
        e.s = sv; e.cout = c; e.ovf = o; e.acc_cyc = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic c, input logic sb_);
        exp_t e;
        int ua, ub, sa, sbv, r, sr;
        ua = int'(av); ub = int'(bv);
        sa = int'($signed(av)); sbv = int'($signed(bv));
        if (!sb_) begin
            r = ua + ub + int'(c);
            sr = sa + sbv + int'(c);
            e.cout = (r >= (1 << W));
        end else begin
            r = ua - ub - int'(c);
            sr = sa - sbv - int'(c);
            e.cout = (ua >= ub + int'(c));
        end
        e.s = r[W-1:0];
        e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        e.acc_cyc = 0;
        return e;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DG = (g == 0) ? 2 : ((g == 1) ? 8 : 1);
        localparam int NDIG = W / DG;
        bit seen = 1'b0;

        addsub_serial #(.WIDTH(W), .DIGIT(DG)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
            .a_i(a[g]), .b_i(b[g]), .cin_i(cin[g]), .sub_i(sub[g]),
            .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
            .s_o(s[g]), .cout_o(cout[g]), .ovf_o(ovf[g]), .busy_o(busy[g])
        );

        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid[g]) begin
                if (!seen) begin
                    if (sb[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL d%0d_unexpected_output: got s=0x%0h with no operation pending", DG, s[g]);
                    end else begin
                        chk($sformatf("d%0d_latency", DG), 32'(cyc - sb[g][0].acc_cyc), 32'(NDIG));
                    end
                    seen = 1'b1;
                end
                if (out_ready[g]) begin
                    if (sb[g].size() > 0) begin
                        e = sb[g].pop_front();
                        chk($sformatf("d%0d_result{s,cout,ovf}", DG),
                            {22'd0, s[g], cout[g], ovf[g]}, {22'd0, e.s, e.cout, e.ovf});
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    // Caller is positioned just after a rising edge; returns just after the accept edge.
    task automatic send(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c, input logic sb_, input exp_t e);
        bit rdy;
        int n;
        n = 0;
        in_valid[i] = 1'b1; a[i] = av; b[i] = bv; cin[i] = c; sub[i] = sb_;
        do begin
            rdy = in_ready[i];
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 500);
        in_valid[i] = 1'b0;
        a[i] = W'($urandom); b[i] = W'($urandom);
        cin[i] = 1'($urandom); sub[i] = 1'($urandom);
        if (!rdy) begin
            note_fail($sformatf("accept_timeout_%0d", i));
        end else begin
            e.acc_cyc = cyc;
            sb[i].push_back(e);
        end
    endtask

    task automatic wait_drain(input int i);
        int n;
        n = 0;
        while (sb[i].size() > 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb[i].size() > 0) note_fail($sformatf("drain_timeout_%0d", i));
    endtask

    task automatic run_rand(input int i);
        logic [W-1:0] av, bv;
        logic c, sb_;
        for (int k = 0; k < 200; k++) begin
            av = W'($urandom); bv = W'($urandom);
            c = 1'($urandom); sb_ = 1'($urandom);
            send(i, av, bv, c, sb_, model(av, bv, c, sb_));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_drain(i);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_mode) begin
                for (int i = 0; i < N; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0; a[i] = '0; b[i] = '0; cin[i] = 1'b0; sub[i] = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_s", 32'(s[0]), 32'h0);
        chk("reset_cout", 32'(cout[0]), 32'h0);
        chk("reset_ovf", 32'(ovf[0]), 32'h0);
        chk("reset_out_valid", 32'(out_valid[0]), 32'h0);
        chk("reset_busy", 32'(busy[0]), 32'h0);
        chk("reset_in_ready", 32'(in_ready[0]), 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic cases, consumer always ready.
        out_ready[0] = 1'b1;
        send(0, 8'd10, 8'd20, 1'b1, 1'b0, mk(8'd31, 1'b0, 1'b0));
        chk("busy_in_calc", 32'(busy[0]), 32'h1);
        chk("in_ready_low_in_calc", 32'(in_ready[0]), 32'h0);
        send(0, 8'd15, 8'd12, 1'b0, 1'b1, mk(8'd3, 1'b1, 1'b0));
        send(0, 8'd4, 8'd14, 1'b0, 1'b1, mk(8'hF6, 1'b0, 1'b0));
        send(0, 8'd100, 8'd100, 1'b0, 1'b0, mk(8'hC8, 1'b0, 1'b1));
        send(0, 8'hFE, 8'hFD, 1'b0, 1'b0, mk(8'hFB, 1'b1, 1'b0));
        send(0, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1));
        wait_drain(0);

        // Hold the result in DONE while new operands are offered.
        out_ready[0] = 1'b0;
        send(0, 8'd100, 8'd100, 1'b0, 1'b0, mk(8'hC8, 1'b0, 1'b1));
        n = 0;
        while (!out_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
        if (!out_valid[0]) note_fail("stall_wait_out_valid");
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", 32'(out_valid[0]), 32'h1);
            chk("stall_s", 32'(s[0]), 32'hC8);
            chk("stall_flags", {30'd0, cout[0], ovf[0]}, 32'h1);
            chk("stall_in_ready", 32'(in_ready[0]), 32'h0);
            in_valid[0] = (k % 2 == 0);
            a[0] = 8'd1; b[0] = 8'd1; cin[0] = 1'b0; sub[0] = 1'b0;
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("take_out_valid_drops", 32'(out_valid[0]), 32'h0);
        chk("take_in_ready_rises", 32'(in_ready[0]), 32'h1);
        chk("take_sb_empty", 32'(sb[0].size()), 32'h0);
        repeat (10) begin @(posedge clk); #1; end

        // Reset in the middle of a computation discards it.
        send(0, 8'd50, 8'd60, 1'b0, 1'b0, mk(8'h6E, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_s", 32'(s[0]), 32'h0);
        chk("midrst_flags", {30'd0, cout[0], ovf[0]}, 32'h0);
        chk("midrst_out_valid", 32'(out_valid[0]), 32'h0);
        chk("midrst_busy", 32'(busy[0]), 32'h0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'h1);
        sb[0].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("post_rst_no_output", 32'(out_valid[0]), 32'h0);
            @(posedge clk); #1;
        end
        send(0, 8'd0, 8'd0, 1'b1, 1'b1, mk(8'hFF, 1'b0, 1'b0));
        wait_drain(0);

        // Random traffic with backpressure on all three builds.
        rand_mode = 1'b1;
        fork
            run_rand(0);
            run_rand(1);
            run_rand(2);
        join
        rand_mode = 1'b0;
        repeat (20) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
